load_unit: RTL and testbench

Load-return controller for the MEM/WB boundary of the five-stage pipeline. It tracks up to DEPTH in-order outstanding data-SRAM loads, captures each returning 32-bit word, selects the byte, halfword or word addressed by the load, and applies sign or zero extension. Results are handed to write-back through a valid/ready handshake. A pipeline flush discards all outstanding loads, including responses still in flight.

---
 rtl/mips_load_pkg.sv | 35 +++
 rtl/load_align.sv | 36 +++
 rtl/load_unit.sv | 191 +++++++++++++++++++
 tb/tb_load_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_load_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_load_pkg
// Brief    : Shared load-op encoding and the alignment check used by the
//            MEM/WB load-return path.
// Revision : 1.0 - initial release
// ============================================================================
package mips_load_pkg;

    localparam int LOAD_OP_W = 3;

    typedef enum logic [LOAD_OP_W-1:0] {
        LB  = 3'd0,
        LBU = 3'd1,
        LH  = 3'd2,
        LHU = 3'd3,
        LW  = 3'd4
    } load_op_e;

    // Halfwords need an even offset and words need offset 0; the unused
    // encodings 5-7 behave as LW.
    function automatic logic is_misaligned(input logic [LOAD_OP_W-1:0] op,
                                           input logic [1:0]           addr_lo);
        logic mis;
        mis = 1'b0;
        case (op)
            LB, LBU: mis = 1'b0;
            LH, LHU: mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module   : load_align
// Brief    : Selects the byte/half/word addressed by a load from a returned
//            little-endian memory word and sign- or zero-extends it.
// Revision : 1.0 - initial release
// ============================================================================
module load_align
    import mips_load_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [LOAD_OP_W-1:0] op_i,
    input  logic [1:0]           addr_lo_i,
    input  logic [DATA_W-1:0]    rdata_i,
    output logic [DATA_W-1:0]    data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Field selection and extension are purely combinational.
    always_comb begin
        w_byte = rdata_i[8*addr_lo_i +: 8];
        w_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (op_i)
            LB:      data_o = {{(DATA_W-8){w_byte[7]}}, w_byte};
            LBU:     data_o = {{(DATA_W-8){1'b0}}, w_byte};
            LH:      data_o = {{(DATA_W-16){w_half[15]}}, w_half};
            LHU:     data_o = {{(DATA_W-16){1'b0}}, w_half};
            default: data_o = rdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_unit
// Brief    : In-order load-return queue for the MEM/WB boundary. Tracks up to
//            DEPTH outstanding loads, aligns/extends each returning word and
//            hands results to write-back over valid/ready. Flush discards all
//            entries and drops responses still in flight.
// Revision : 1.0 - initial release
// ============================================================================
module load_unit
    import mips_load_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_op,
    input  logic [1:0]           req_addr_lo,
    input  logic [4:0]           req_rd,
    output logic                 misalign,
    input  logic                 mem_rvalid,
    input  logic [DATA_W-1:0]    mem_rdata,
    input  logic                 flush,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [DATA_W-1:0]    wb_data,
    output logic [4:0]           wb_rd,
    output logic                 busy
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(DEPTH);

    // Per-entry storage
    logic [LOAD_OP_W-1:0] op_q      [DEPTH];
    logic [1:0]           addr_lo_q [DEPTH];
    logic [4:0]           rd_q      [DEPTH];
    logic [DATA_W-1:0]    data_q    [DEPTH];
    logic [DEPTH-1:0]     done_q;

    // Pointers and counters; pend counts entries still awaiting a response.
    logic [c_PTR_W-1:0] head_q, head_d;
    logic [c_PTR_W-1:0] resp_q, resp_d;
    logic [c_PTR_W-1:0] tail_q, tail_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic [c_CNT_W-1:0] pend_q, pend_d;
    logic [c_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic              w_misalign;
    logic              w_req_ready;
    logic              w_enq;
    logic              w_wb_valid;
    logic              w_deq;
    logic              w_drop;
    logic              w_resp;
    logic [c_CNT_W-1:0] w_flush_total;
    logic [DATA_W-1:0] w_resp_data;

    // Handshake and event decode
    always_comb begin
        w_misalign    = req_valid && is_misaligned(req_op, req_addr_lo);
        w_req_ready   = resetn && (count_q < c_DEPTH) && (drop_cnt_q == '0);
        w_enq         = req_valid && w_req_ready && !w_misalign && !flush;
        w_wb_valid    = done_q[head_q] && !flush;
        w_deq         = w_wb_valid && wb_ready;
        w_drop        = mem_rvalid && (drop_cnt_q != '0);
        w_resp        = mem_rvalid && (drop_cnt_q == '0) && (pend_q != '0);
        w_flush_total = pend_q + drop_cnt_q;
    end

    // Response word is aligned using the op/offset of the entry it answers.
    load_align #(
        .DATA_W    (DATA_W)
    ) u_align (
        .op_i      (op_q[resp_q]),
        .addr_lo_i (addr_lo_q[resp_q]),
        .rdata_i   (mem_rdata),
        .data_o    (w_resp_data)
    );

    // Next-state for pointers and counters; flush overrides every transfer.
    always_comb begin
        head_d     = head_q;
        resp_d     = resp_q;
        tail_d     = tail_q;
        count_d    = count_q;
        pend_d     = pend_q;
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            head_d  = '0;
            resp_d  = '0;
            tail_d  = '0;
            count_d = '0;
            pend_d  = '0;
            // A response landing with the flush is already consumed.
            if (mem_rvalid && (w_flush_total != '0)) begin
                drop_cnt_d = w_flush_total - c_CNT_ONE;
            end else begin
                drop_cnt_d = w_flush_total;
            end
        end else begin
            if (w_enq)  tail_d = tail_q + c_PTR_ONE;
            if (w_deq)  head_d = head_q + c_PTR_ONE;
            if (w_resp) resp_d = resp_q + c_PTR_ONE;
            if (w_drop) drop_cnt_d = drop_cnt_q - c_CNT_ONE;
            case ({w_enq, w_deq})
                2'b10:   count_d = count_q + c_CNT_ONE;
                2'b01:   count_d = count_q - c_CNT_ONE;
                default: count_d = count_q;
            endcase
            case ({w_enq, w_resp})
                2'b10:   pend_d = pend_q + c_CNT_ONE;
                2'b01:   pend_d = pend_q - c_CNT_ONE;
                default: pend_d = pend_q;
            endcase
        end
    end

    // Pointer and counter registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q     <= '0;
            resp_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            pend_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            head_q     <= head_d;
            resp_q     <= resp_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Entry storage: enqueue writes tail, response fills resp, dequeue frees head.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            done_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]      <= '0;
                addr_lo_q[i] <= '0;
                rd_q[i]      <= '0;
                data_q[i]    <= '0;
            end
        end else if (flush) begin
            done_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            if (w_enq) begin
                op_q[tail_q]      <= req_op;
                addr_lo_q[tail_q] <= req_addr_lo;
                rd_q[tail_q]      <= req_rd;
                done_q[tail_q]    <= 1'b0;
            end
            if (w_resp) begin
                data_q[resp_q] <= w_resp_data;
                done_q[resp_q] <= 1'b1;
            end
            if (w_deq) begin
                done_q[head_q] <= 1'b0;
            end
        end
    end

    // Output drive
    always_comb begin
        req_ready = w_req_ready;
        misalign  = w_misalign;
        wb_valid  = w_wb_valid;
        wb_data   = data_q[head_q];
        wb_rd     = rd_q[head_q];
        busy      = (count_q != '0) || (drop_cnt_q != '0);
    end

    // A response must always answer a pending entry or a dropped one.
    a_no_orphan_resp: assert property (@(posedge clk) disable iff (!resetn)
        mem_rvalid |-> ((pend_q != '0) || (drop_cnt_q != '0)));

endmodule
`default_nettype wire

// File: tb/tb_load_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_unit
// Brief    : Directed self-checking bench for load_unit (DEPTH=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_unit;

    logic        clk;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [1:0]  req_addr_lo;
    logic [4:0]  req_rd;
    logic        misalign;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        flush;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        busy;

    int vectors;
    int miscompares;

    load_unit #(.DEPTH(2), .DATA_W(32)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr_lo (req_addr_lo),
        .req_rd      (req_rd),
        .misalign    (misalign),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .flush       (flush),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_data     (wb_data),
        .wb_rd       (wb_rd),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] a, input logic [4:0] rd);
        req_valid   = 1'b1;
        req_op      = op;
        req_addr_lo = a;
        req_rd      = rd;
        tick();
        req_valid   = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rdata);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        tick();
        mem_rvalid = 1'b0;
    endtask

    // Single load: issue, respond next cycle, check result, drain.
    task automatic do_load(input string tag, input logic [2:0] op, input logic [1:0] a,
                           input logic [4:0] rd, input logic [31:0] rdata,
                           input logic [31:0] exp);
        issue(op, a, rd);
        check({tag, "_pending"}, {31'd0, wb_valid}, 32'd0);
        respond(rdata);
        check({tag, "_valid"}, {31'd0, wb_valid}, 32'd1);
        check({tag, "_data"}, wb_data, exp);
        check({tag, "_rd"}, {27'd0, wb_rd}, {27'd0, rd});
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        check({tag, "_drained"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetn      = 1'b0;
        req_valid   = 1'b0;
        req_op      = 3'd0;
        req_addr_lo = 2'd0;
        req_rd      = 5'd0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'd0;
        flush       = 1'b0;
        wb_ready    = 1'b0;

        // Reset state
        #3;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_wb_valid",  {31'd0, wb_valid},  32'd0);
        check("rst_wb_data",   wb_data,            32'd0);
        check("rst_wb_rd",     {27'd0, wb_rd},     32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_misalign",  {31'd0, misalign},  32'd0);
        tick();
        tick();
        resetn = 1'b1;
        tick();
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);

        // Extraction and extension
        do_load("lb",  3'd0, 2'd3, 5'd5, 32'h8012_3456, 32'hFFFF_FF80);
        do_load("lbu", 3'd1, 2'd3, 5'd6, 32'h8012_3456, 32'h0000_0080);
        do_load("lh",  3'd2, 2'd2, 5'd7, 32'h8001_7FFF, 32'hFFFF_8001);
        do_load("lhu", 3'd3, 2'd2, 5'd8, 32'h8001_7FFF, 32'h0000_8001);
        do_load("lw",  3'd4, 2'd0, 5'd9, 32'h8001_7FFF, 32'h8001_7FFF);
        do_load("lh_lo", 3'd2, 2'd0, 5'd12, 32'h1234_F00D, 32'hFFFF_F00D);

        // Misalignment
        req_valid = 1'b1; req_op = 3'd4; req_addr_lo = 2'd1; req_rd = 5'd3;
        #1;
        check("mis_lw_flag",  {31'd0, misalign},  32'd1);
        check("mis_lw_ready", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        check("mis_lw_noenq", {31'd0, busy}, 32'd0);
        check("mis_lw_count", {30'd0, dut.count_q}, 32'd0);
        req_valid = 1'b1; req_op = 3'd3; req_addr_lo = 2'd1;
        #1;
        check("mis_lhu_flag", {31'd0, misalign}, 32'd1);
        req_op = 3'd2; req_addr_lo = 2'd2;
        #1;
        check("ok_lh_flag", {31'd0, misalign}, 32'd0);
        req_op = 3'd7; req_addr_lo = 2'd2;
        #1;
        check("mis_op7_flag", {31'd0, misalign}, 32'd1);
        req_valid = 1'b0;
        #1;
        check("mis_idle_flag", {31'd0, misalign}, 32'd0);
        tick();

        // Fill the queue with write-back stalled, then drain in order
        issue(3'd4, 2'd0, 5'd10);
        check("full_ready1", {31'd0, req_ready}, 32'd1);
        issue(3'd1, 2'd1, 5'd11);
        check("full_ready0", {31'd0, req_ready}, 32'd0);
        respond(32'hAABB_CCDD);
        check("full_v1",  {31'd0, wb_valid}, 32'd1);
        check("full_d1",  wb_data, 32'hAABB_CCDD);
        check("full_rd1", {27'd0, wb_rd}, 32'd10);
        respond(32'h1122_3344);
        check("full_hold_d1", wb_data, 32'hAABB_CCDD);
        check("full_hold_v1", {31'd0, wb_valid}, 32'd1);
        wb_ready = 1'b1;
        tick();
        check("full_v2",  {31'd0, wb_valid}, 32'd1);
        check("full_d2",  wb_data, 32'h0000_0033);
        check("full_rd2", {27'd0, wb_rd}, 32'd11);
        check("full_ready_after_deq", {31'd0, req_ready}, 32'd1);
        tick();
        wb_ready = 1'b0;
        check("full_empty_v", {31'd0, wb_valid}, 32'd0);
        check("full_empty_busy", {31'd0, busy}, 32'd0);

        // Flush with two loads outstanding
        issue(3'd4, 2'd0, 5'd3);
        issue(3'd4, 2'd0, 5'd4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_busy",  {31'd0, busy},      32'd1);
        check("fl_ready", {31'd0, req_ready}, 32'd0);
        check("fl_drop",  {30'd0, dut.drop_cnt_q}, 32'd2);
        check("fl_count", {30'd0, dut.count_q},    32'd0);
        check("fl_wbv",   {31'd0, wb_valid},  32'd0);
        respond(32'hDEAD_BEEF);
        check("fl_ready_d1", {31'd0, req_ready}, 32'd0);
        check("fl_wbv_d1",   {31'd0, wb_valid},  32'd0);
        respond(32'hCAFE_F00D);
        check("fl_ready_d0", {31'd0, req_ready}, 32'd1);
        check("fl_busy_d0",  {31'd0, busy},      32'd0);
        check("fl_wbv_d0",   {31'd0, wb_valid},  32'd0);
        do_load("fl_new", 3'd3, 2'd2, 5'd7, 32'hFEDC_0000, 32'h0000_FEDC);

        // Flush coinciding with a response: that response is consumed
        issue(3'd4, 2'd0, 5'd1);
        issue(3'd4, 2'd0, 5'd2);
        flush      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BAD_0BAD;
        tick();
        flush      = 1'b0;
        mem_rvalid = 1'b0;
        check("flr_drop",  {30'd0, dut.drop_cnt_q}, 32'd1);
        check("flr_ready", {31'd0, req_ready}, 32'd0);
        respond(32'h0BAD_0BAD);
        check("flr_ready1", {31'd0, req_ready}, 32'd1);
        check("flr_busy",   {31'd0, busy},      32'd0);

        // Asynchronous reset with two completed entries waiting
        issue(3'd4, 2'd0, 5'd20);
        issue(3'd4, 2'd0, 5'd21);
        respond(32'h0000_0001);
        respond(32'h0000_0002);
        check("ar_pre_valid", {31'd0, wb_valid}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("ar_wbv",   {31'd0, wb_valid},  32'd0);
        check("ar_ready", {31'd0, req_ready}, 32'd0);
        check("ar_busy",  {31'd0, busy},      32'd0);
        check("ar_data",  wb_data,            32'd0);
        resetn = 1'b1;
        tick();
        check("ar_rel_ready", {31'd0, req_ready}, 32'd1);
        check("ar_rel_wbv",   {31'd0, wb_valid},  32'd0);
        check("ar_rel_busy",  {31'd0, busy},      32'd0);
        do_load("ar_new", 3'd0, 2'd1, 5'd30, 32'h0000_7F00, 32'h0000_007F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
